block_accumulator: RTL
======================

// Module: block_accumulator
// PURPOSE
//   Upstream feeder for divide_by_n: sums NUM_SAMPLES consecutive input samples and issues the block total as one
//   dividend pulse. With divide_by_n DIVISOR == NUM_SAMPLES, the pair produces a rounded block average.
//   Tracks the one in-flight divide and holds at most one further total while the divider is busy.
// PARAMETERS
//   IWIDTH       16  input sample width, unsigned; IWIDTH <= DWIDTH
//   DWIDTH       32  dividend width; must equal divide_by_n DWIDTH
//   NUM_SAMPLES  43  samples per block, >= 1; equals divide_by_n DIVISOR
// PORTS
//   clk           in   1       clock
//   rst           in   1       synchronous, active-high reset
//   i_sample      in   IWIDTH  unsigned sample
//   i_sample_v    in   1       sample valid, one sample per high cycle
//   i_clear       in   1       discard the partial block (count/sum -> 0)
//   i_quotient_v  in   1       divide_by_n o_quotient_v: outstanding divide done
//   o_dividend    out  DWIDTH  block total to divide_by_n i_dividend
//   o_dividend_v  out  1       one-cycle pulse to divide_by_n i_dividend_v
//   o_busy        out  1       a divide is outstanding
//   o_overflow    out  1       sticky: a block total saturated
//   o_drop        out  1       one-cycle pulse: a completed block was discarded
// BEHAVIOUR
//   Reset: every output 0; cnt=0, sum=0, hold_v=0, state=IDLE. Reset mid-block or mid-divide abandons all work.
//     A late i_quotient_v after reset is ignored in IDLE.
//   Accumulate: each i_sample_v cycle: sum <= sat(sum + i_sample), cnt <= cnt+1.
//     sat() clamps to 2^DWIDTH-1 and sets o_overflow; o_overflow clears only on rst.
//   Block end: the cycle with i_sample_v and cnt==NUM_SAMPLES-1 completes the block.
//     total = sat(sum + i_sample); cnt, sum -> 0 on the same edge; NUM_SAMPLES==1 means every sample is a block.
//   i_clear: cnt, sum -> 0; the sample arriving that same cycle is discarded.
//     No effect on hold, state, o_busy or o_overflow.
//   Issue FSM (encoded in the shared package):
//     IDLE: on block end -> o_dividend=total, o_dividend_v=1 on the next cycle; -> BUSY.
//     BUSY: o_busy=1.
//       Block end with hold empty -> hold=total, hold_v=1.
//       Block end with hold full -> block discarded; o_drop pulses 1 cycle; hold unchanged.
//       i_quotient_v with hold_v=1 -> issue hold next cycle, hold_v=0, stay BUSY.
//       i_quotient_v with hold_v=0 -> IDLE.
//   Simultaneous i_quotient_v and block end in BUSY:
//     hold_v=0 -> issue the new total directly; stay BUSY.
//     hold_v=1 -> issue hold, new total -> hold; no drop.
//   Latency: o_dividend_v is registered, asserted in the cycle after the edge that sampled the completing sample
//     (or i_quotient_v). Never two pulses within one divide. o_dividend holds its value until the next issue.
//   o_busy rises with o_dividend_v and falls in the cycle after the i_quotient_v that leaves no hold.
//   Width: sum and hold are DWIDTH; cnt is clog2(NUM_SAMPLES) bits (min 1); i_sample is zero-extended.
// STRUCTURE
//   Shared package: issue-state enum {IDLE, BUSY}, constant function clog2, parameter-legality checks
//     (IWIDTH<=DWIDTH, NUM_SAMPLES>=1).
//   One sub-module: sat_add (DWIDTH unsigned add with saturation and overflow flag),
//     instanced once for the running sum.
//   Counter, hold register and issue FSM stay in this module.
// TESTING (NUM_SAMPLES=43, IWIDTH=16, DWIDTH=32, chained to divide_by_n DIVISOR=43)
//   43 samples of 1000, back-to-back
//     -> one o_dividend_v, o_dividend=43000, quotient 1000 in [999,1001]; o_busy falls after o_quotient_v.
//   Ramp 0..42 -> o_dividend=903, quotient 21 +/-1.
//     Then 10 samples, i_clear, 43 samples of 5 -> o_dividend=215 with no residue from the cleared 10.
//   Stub divider, i_quotient_v withheld; 3 blocks of 1 -> issue 43; hold=43; 3rd block -> o_drop one pulse.
//     Release i_quotient_v -> held 43 issued next cycle.
//   DWIDTH=16 build, 43 samples of 0xFFFF -> o_dividend=0xFFFF, o_overflow=1 and stays 1 across the next block.
//   i_quotient_v coincident with a block end, hold full -> hold issued, new total held, no o_drop.
//   rst asserted mid-block and while BUSY -> all outputs 0 next cycle; stray i_quotient_v ignored;
//     next full block issues normally.

Source files
------------

// File: rtl/block_accumulator_pkg.sv
// Shared definitions for block_accumulator.
//   issue_state_t : issue FSM encoding (IDLE = no divide outstanding, BUSY = one divide in flight)
//   clog2         : constant ceil(log2(n)), 0 for n <= 1
//   params_legal  : elaboration-time parameter sanity check
package block_accumulator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } issue_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit params_legal(input int iw, input int dw, input int ns);
    return (iw >= 1) && (iw <= dw) && (ns >= 1);
  endfunction

endpackage

// File: rtl/block_accumulator_sat_add.sv
// Unsigned W-bit adder that clamps to all-ones on carry out.
//   a, b : operands
//   sum  : saturated a + b
//   ovf  : 1 when the true sum did not fit in W bits
module block_accumulator_sat_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[W];
  assign sum  = ovf ? '1 : full[W-1:0];

endmodule

// File: rtl/block_accumulator.sv
// Sums NUM_SAMPLES consecutive samples and hands each block total to a
// divide-by-N unit as a single dividend pulse. One divide may be in flight;
// one further total can wait in the hold register, anything beyond is dropped.
//   clk, rst      : clock, synchronous active-high reset
//   i_sample(_v)  : unsigned sample and its valid
//   i_clear       : discard the partial block (same-cycle sample is discarded too)
//   i_quotient_v  : the outstanding divide has finished
//   o_dividend(_v): block total and its one-cycle issue pulse
//   o_busy        : a divide is outstanding
//   o_overflow    : sticky, some block total saturated
//   o_drop        : one-cycle pulse, a completed block was discarded
module block_accumulator
  import block_accumulator_pkg::*;
#(
  parameter int IWIDTH      = 16,
  parameter int DWIDTH      = 32,
  parameter int NUM_SAMPLES = 43
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IWIDTH-1:0] i_sample,
  input  logic              i_sample_v,
  input  logic              i_clear,
  input  logic              i_quotient_v,
  output logic [DWIDTH-1:0] o_dividend,
  output logic              o_dividend_v,
  output logic              o_busy,
  output logic              o_overflow,
  output logic              o_drop
);

  localparam int            CW       = (clog2(NUM_SAMPLES) < 1) ? 1 : clog2(NUM_SAMPLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_SAMPLES - 1);

  generate
    if (!params_legal(IWIDTH, DWIDTH, NUM_SAMPLES)) begin : g_bad_params
      $error("block_accumulator: need 1 <= IWIDTH <= DWIDTH and NUM_SAMPLES >= 1");
    end
  endgenerate

  issue_state_t      state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [DWIDTH-1:0] sum_q, hold_q, hold_d, add_sum, smp_ext, issue_val;
  logic              hold_v_q, hold_v_d, add_ovf, take, blk_end, issue, drop_d;

  assign smp_ext = DWIDTH'(i_sample);
  assign take    = i_sample_v & ~i_clear;
  // add_sum is the block total on the completing cycle
  assign blk_end = take & (cnt_q == CNT_LAST);

  block_accumulator_sat_add #(.W(DWIDTH)) u_sum (
    .a   (sum_q),
    .b   (smp_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // accumulator and sample counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      sum_q      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (take && add_ovf) o_overflow <= 1'b1;
      if (i_clear || blk_end) begin
        cnt_q <= '0;
        sum_q <= '0;
      end else if (i_sample_v) begin
        cnt_q <= cnt_q + CW'(1);
        sum_q <= add_sum;
      end
    end
  end

  // issue FSM: next state, hold update, issue/drop decisions
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    issue_val = hold_q;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    drop_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // a stray quotient here is ignored
        if (blk_end) begin
          issue     = 1'b1;
          issue_val = add_sum;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (i_quotient_v) begin
          if (hold_v_q) begin
            // held total goes out; a coincident new total takes its place
            issue     = 1'b1;
            issue_val = hold_q;
            hold_v_d  = blk_end;
            if (blk_end) hold_d = add_sum;
          end else if (blk_end) begin
            issue     = 1'b1;
            issue_val = add_sum;
          end else begin
            state_d = IDLE;
          end
        end else if (blk_end) begin
          if (hold_v_q) begin
            drop_d = 1'b1;
          end else begin
            hold_d   = add_sum;
            hold_v_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_v_q     <= 1'b0;
      o_dividend   <= '0;
      o_dividend_v <= 1'b0;
      o_drop       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_v_q     <= hold_v_d;
      o_dividend_v <= issue;
      o_drop       <= drop_d;
      if (issue) o_dividend <= issue_val;
    end
  end

  assign o_busy = (state_q == BUSY);

endmodule
